vga_pattern_sequencer: RTL and testbench
========================================

// Module: vga_pattern_sequencer
// PURPOSE
//  Frame-level scheduler for the VGA test-pattern datapath. It watches the controller's
//  vertical sync and selects which test pattern the pixel painter draws. Patterns advance
//  automatically every FRAMES_PER_PATTERN frames or on a manual request. The selection
//  changes only at a frame boundary, so no frame is ever torn between two patterns.
// PARAMETERS
//  NUM_PATTERNS        4   number of patterns; legal range 2..16; index wraps at NUM_PATTERNS-1
//  FRAMES_PER_PATTERN  60  frames per pattern in auto mode; legal range 1..256
//  PAT_W               4   width of oPATTERN; must satisfy 2^PAT_W >= NUM_PATTERNS
// PORTS
//  iCLK          in   1      pixel clock (25 MHz VGA clock)
//  iRST          in   1      asynchronous reset, active-high
//  iVGA_VS       in   1      VGA V_SYNC from the controller, active-low, same clock domain
//  iENABLE       in   1      1 = auto-advance enabled
//  iNEXT_REQ     in   1      manual advance request, level; held by the requester until oNEXT_ACK
//  oNEXT_ACK     out  1      1-cycle pulse: manual request has been serviced
//  oPATTERN      out  PAT_W  current pattern index, drives the painter's pattern mux
//  oFRAME_CNT    out  8      frames shown since the last pattern change
//  oFRAME_START  out  1      1-cycle pulse at each frame boundary
//  oSWITCH       out  1      1-cycle pulse when oPATTERN changes
// BEHAVIOUR
//  - Reset (async, iRST=1) forces the following immediately:
//    oPATTERN=0, oFRAME_CNT=0, oNEXT_ACK=0, oFRAME_START=0, oSWITCH=0,
//    vs_d=0, pending=0, armed=1, state=WAIT_SYNC.
//  - Frame boundary: boundary = vs_d & ~iVGA_VS (VS falling edge). vs_d is iVGA_VS registered.
//    Because vs_d resets to 0, a VS held low through reset release never counts as an edge.
//  - Every output is registered. All effects of a boundary detected in cycle T appear at
//    T+1: FRAME_START, SWITCH, ACK, PATTERN and FRAME_CNT.
//  - Request capture:
//    - When iNEXT_REQ=1, armed=1 and pending=0: set pending=1 and armed=0.
//    - armed returns to 1 only after iNEXT_REQ is sampled at 0.
//    - A request held high after its ack therefore produces exactly one advance.
//  - FSM state WAIT_SYNC:
//    - Pending requests are captured but not serviced.
//    - The first boundary pulses oFRAME_START, sets oFRAME_CNT=0 and moves to RUN.
//    - No pattern advance occurs on this alignment boundary.
//  - FSM state RUN, on each boundary:
//    - adv_auto = iENABLE & (oFRAME_CNT == FRAMES_PER_PATTERN-1)
//    - adv = adv_auto | pending
//    - If adv: oPATTERN <= (oPATTERN==NUM_PATTERNS-1) ? 0 : oPATTERN+1; oFRAME_CNT <= 0;
//      oSWITCH pulses.
//    - If pending was 1: oNEXT_ACK pulses and pending clears.
//    - If no advance and iENABLE=1: oFRAME_CNT increments.
//    - If no advance and iENABLE=0: oFRAME_CNT holds.
//  - Auto and manual advance on the same boundary: the pattern advances by exactly 1 and
//    the request is acked.
//  - A request that arrives in the same cycle as a boundary is captured and serviced at the
//    next boundary. It is not serviced at the current one.
//  - oPATTERN is never modified between boundaries.
//  - FRAMES_PER_PATTERN=1 with iENABLE=1: the pattern advances on every RUN boundary.
//  - Reset asserted mid-frame: any pending request is dropped with no ack. The requester
//    must re-raise it.
// TESTING
//  1. Reset with VS held low, release, keep VS low 20 cycles.
//     -> no oFRAME_START; oPATTERN=0; state stays WAIT_SYNC.
//  2. FPP=3, NUM=4, iENABLE=1, drive 13 VS falling edges.
//     -> oSWITCH after edges 4, 7, 10 and 13; oPATTERN goes 1, 2, 3, 0 (wrap).
//  3. Raise iNEXT_REQ mid-frame and hold it for 3 frames.
//     -> one oNEXT_ACK, one cycle after the next VS fall; oPATTERN+1; oFRAME_CNT=0;
//        no second advance.
//  4. FPP=3 with the request pending while oFRAME_CNT=2.
//     -> next boundary advances oPATTERN by exactly 1, with oNEXT_ACK=1 and oSWITCH=1.
//  5. iENABLE=0 for 5 frames with oFRAME_CNT=1.
//     -> oFRAME_CNT stays 1 and oPATTERN holds; a manual request during this window still
//        advances the pattern.
//  6. Assert iRST mid-frame with a request pending, with no iCLK edge.
//     -> all outputs are 0 at once; after release no ack is produced until a new request.

Source files
------------

// File: rtl/vga_pattern_sequencer.sv
// Frame-level test-pattern scheduler: advances the painter's pattern index on VS frame
// boundaries, either automatically every FRAMES_PER_PATTERN frames or on a manual request.
//
//   state        | meaning
//   ST_WAIT_SYNC | waiting for the first VS fall after reset to align to the frame
//   ST_RUN       | aligned; boundaries count frames and may advance the pattern
module vga_pattern_sequencer #(
   parameter int NUM_PATTERNS       = 4,
   parameter int FRAMES_PER_PATTERN = 60,
   parameter int PAT_W              = 4
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iVGA_VS,
   input  logic             iENABLE,
   input  logic             iNEXT_REQ,
   output logic             oNEXT_ACK,
   output logic [PAT_W-1:0] oPATTERN,
   output logic [7:0]       oFRAME_CNT,
   output logic             oFRAME_START,
   output logic             oSWITCH
);

   typedef enum logic {ST_WAIT_SYNC, ST_RUN} state_t;

   localparam logic [7:0]       LP_CNT_LAST = 8'(FRAMES_PER_PATTERN - 1);
   localparam logic [PAT_W-1:0] LP_PAT_LAST = PAT_W'(NUM_PATTERNS - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_vs_d;
   logic             r_pending;
   logic             r_armed;

   logic             w_boundary;
   logic             w_adv;
   logic             w_pending_nxt;
   logic             w_armed_nxt;
   logic [PAT_W-1:0] w_pattern_nxt;
   logic [7:0]       w_cnt_nxt;
   logic             w_fs_nxt;
   logic             w_sw_nxt;
   logic             w_ack_nxt;

   // vs_d resets low so a VS held low across reset release is not seen as an edge
   assign w_boundary = r_vs_d & ~iVGA_VS;
   assign w_adv      = (iENABLE & (oFRAME_CNT == LP_CNT_LAST)) | r_pending;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_state <= ST_WAIT_SYNC;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_WAIT_SYNC && w_boundary) begin
         w_state_nxt = ST_RUN;
      end
   end

   always_comb begin
      w_pattern_nxt = oPATTERN;
      w_cnt_nxt     = oFRAME_CNT;
      w_fs_nxt      = w_boundary;
      w_sw_nxt      = 1'b0;
      w_ack_nxt     = 1'b0;
      w_pending_nxt = r_pending;
      w_armed_nxt   = r_armed;

      // capture only while not pending, so it never collides with the service clear below
      if (iNEXT_REQ && r_armed && !r_pending) begin
         w_pending_nxt = 1'b1;
         w_armed_nxt   = 1'b0;
      end else if (!iNEXT_REQ) begin
         w_armed_nxt   = 1'b1;
      end

      if (w_boundary) begin
         case (r_state)
            ST_WAIT_SYNC: begin
               w_cnt_nxt = 8'd0;
            end
            ST_RUN: begin
               if (r_pending) begin
                  w_ack_nxt     = 1'b1;
                  w_pending_nxt = 1'b0;
               end
               if (w_adv) begin
                  w_pattern_nxt = (oPATTERN == LP_PAT_LAST) ? '0 : oPATTERN + 1'b1;
                  w_cnt_nxt     = 8'd0;
                  w_sw_nxt      = 1'b1;
               end else if (iENABLE) begin
                  w_cnt_nxt     = oFRAME_CNT + 8'd1;
               end
            end
            default: begin
               w_cnt_nxt = oFRAME_CNT;
            end
         endcase
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_vs_d       <= 1'b0;
         r_pending    <= 1'b0;
         r_armed      <= 1'b1;
         oPATTERN     <= '0;
         oFRAME_CNT   <= 8'd0;
         oFRAME_START <= 1'b0;
         oSWITCH      <= 1'b0;
         oNEXT_ACK    <= 1'b0;
      end else begin
         r_vs_d       <= iVGA_VS;
         r_pending    <= w_pending_nxt;
         r_armed      <= w_armed_nxt;
         oPATTERN     <= w_pattern_nxt;
         oFRAME_CNT   <= w_cnt_nxt;
         oFRAME_START <= w_fs_nxt;
         oSWITCH      <= w_sw_nxt;
         oNEXT_ACK    <= w_ack_nxt;
      end
   end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Bench for vga_pattern_sequencer: directed scenarios then randomized frames, all checked
// every cycle against a frame-level reference model.
module tb_vga_pattern_sequencer;
   localparam int NUM = 4;
   localparam int FPP = 3;

   logic       clk, rst, vs, en, req;
   logic       ack, fs, sw;
   logic [3:0] pat;
   logic [7:0] cnt;

   vga_pattern_sequencer #(.NUM_PATTERNS(NUM), .FRAMES_PER_PATTERN(FPP), .PAT_W(4)) dut (
      .iCLK(clk), .iRST(rst), .iVGA_VS(vs), .iENABLE(en), .iNEXT_REQ(req),
      .oNEXT_ACK(ack), .oPATTERN(pat), .oFRAME_CNT(cnt), .oFRAME_START(fs), .oSWITCH(sw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int obs_sw, obs_ack, obs_fs;

   // reference model: frame-level view of the scheduler
   bit m_vs_d, m_aligned, m_pending, m_armed;
   int m_pat, m_cnt;
   bit e_fs, e_sw, e_ack;
   bit rnd_mode, acked;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_vs_d = 0; m_aligned = 0; m_pending = 0; m_armed = 1;
      m_pat = 0; m_cnt = 0; e_fs = 0; e_sw = 0; e_ack = 0;
   endtask

   task automatic tick();
      bit bnd, old_p, adv;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         bnd = m_vs_d && !vs;
         old_p = m_pending;
         e_fs = bnd; e_sw = 0; e_ack = 0;
         if (bnd) begin
            if (!m_aligned) begin
               m_aligned = 1;
               m_cnt = 0;
            end else begin
               adv = (en && m_cnt == FPP - 1) || old_p;
               if (old_p) begin e_ack = 1; m_pending = 0; end
               if (adv) begin m_pat = (m_pat + 1) % NUM; m_cnt = 0; e_sw = 1; end
               else if (en) m_cnt = m_cnt + 1;
            end
         end
         if (req && m_armed && !old_p) begin m_pending = 1; m_armed = 0; end
         else if (!req) m_armed = 1;
         m_vs_d = vs;
      end
      @(negedge clk);
      chk("pattern", 32'(pat), 32'(m_pat));
      chk("frame_cnt", 32'(cnt), 32'(m_cnt));
      chk("frame_start", 32'(fs), 32'(e_fs));
      chk("switch", 32'(sw), 32'(e_sw));
      chk("next_ack", 32'(ack), 32'(e_ack));
      if (sw === 1'b1) obs_sw++;
      if (ack === 1'b1) obs_ack++;
      if (fs === 1'b1) obs_fs++;
   endtask

   task automatic cyc(input logic v);
      vs = v;
      if (rnd_mode) begin
         if (!req && $urandom_range(0, 11) == 0) begin req = 1; acked = 0; end
         else if (req && acked && $urandom_range(0, 2) == 0) req = 0;
      end
      tick();
      if (rnd_mode && e_ack) acked = 1;
   endtask

   task automatic frame(input int hi, input int lo);
      for (int i = 0; i < hi; i++) cyc(1'b1);
      for (int i = 0; i < lo; i++) cyc(1'b0);
   endtask

   task automatic clear_obs();
      obs_sw = 0; obs_ack = 0; obs_fs = 0;
   endtask

   initial begin
      int p0;
      rst = 1; vs = 0; en = 1; req = 0; rnd_mode = 0; acked = 0;
      model_reset();
      clear_obs();
      tick(); tick();
      rst = 0;

      // 1: VS low through reset release never aligns
      clear_obs();
      for (int i = 0; i < 20; i++) cyc(1'b0);
      chk("t1_no_frame_start", 32'(obs_fs), 32'd0);
      chk("t1_pattern", 32'(pat), 32'd0);

      // 2: 13 edges, first aligns, then switches on edges 4,7,10,13
      clear_obs();
      for (int i = 0; i < 13; i++) frame(4, 3);
      chk("t2_switches", 32'(obs_sw), 32'd4);
      chk("t2_frame_starts", 32'(obs_fs), 32'd13);
      chk("t2_pattern_wrap", 32'(pat), 32'd0);

      // 3: request held for 3 frames produces one advance
      en = 0;
      cyc(1'b1); cyc(1'b1);
      clear_obs();
      req = 1;
      for (int i = 0; i < 3; i++) frame(4, 3);
      req = 0;
      cyc(1'b0);
      chk("t3_acks", 32'(obs_ack), 32'd1);
      chk("t3_switches", 32'(obs_sw), 32'd1);
      chk("t3_pattern", 32'(pat), 32'd1);
      chk("t3_frame_cnt", 32'(cnt), 32'd0);

      // 4: pending request coinciding with auto advance: advance by one
      en = 1;
      frame(4, 3); frame(4, 3);
      chk("t4_cnt_setup", 32'(cnt), 32'd2);
      p0 = int'(pat);
      cyc(1'b1); req = 1; cyc(1'b1); cyc(1'b1);
      cyc(1'b0);
      chk("t4_ack", 32'(ack), 32'd1);
      chk("t4_switch", 32'(sw), 32'd1);
      chk("t4_pattern_plus1", 32'(pat), 32'((p0 + 1) % NUM));
      req = 0;
      cyc(1'b0); cyc(1'b0);

      // 5: auto disabled holds count; manual request still advances
      frame(4, 3);
      chk("t5_cnt_setup", 32'(cnt), 32'd1);
      en = 0;
      p0 = int'(pat);
      for (int i = 0; i < 5; i++) frame(4, 3);
      chk("t5_cnt_hold", 32'(cnt), 32'd1);
      chk("t5_pattern_hold", 32'(pat), 32'(p0));
      req = 1;
      frame(4, 3);
      req = 0;
      cyc(1'b0);
      chk("t5_manual_adv", 32'(pat), 32'((p0 + 1) % NUM));

      // 6: async reset mid-frame drops a pending request
      en = 1;
      cyc(1'b1); req = 1; cyc(1'b1); cyc(1'b1);
      rst = 1;
      #1;
      chk("t6_rst_pattern", 32'(pat), 32'd0);
      chk("t6_rst_cnt", 32'(cnt), 32'd0);
      chk("t6_rst_ack", 32'(ack), 32'd0);
      chk("t6_rst_fs", 32'(fs), 32'd0);
      chk("t6_rst_sw", 32'(sw), 32'd0);
      req = 0;
      model_reset();
      tick(); tick();
      rst = 0;
      en = 0;
      clear_obs();
      for (int i = 0; i < 4; i++) frame(3, 2);
      chk("t6_no_ack_after_reset", 32'(obs_ack), 32'd0);

      // randomized frames with a requester that holds until ack
      rnd_mode = 1;
      for (int f = 0; f < 150; f++) begin
         en = ($urandom_range(0, 3) != 0);
         frame($urandom_range(1, 6), $urandom_range(1, 5));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
